// File: rtl/disp_7seg_scan_if.sv
// Bus between a value producer and the multiplexed 7-segment driver.
// The producer (master) offers a value plus a load request. The driver (slave)
// reports busy and drives the shared segment bus and the digit enables.
interface disp_7seg_scan_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
) ();
    logic [WIDTH-1:0]  in_val;
    logic              in_signed;
    logic              load;
    logic              busy;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    modport master (
        output in_val, in_signed, load,
        input  busy, seg, an
    );

    modport slave (
        input  in_val, in_signed, load,
        output busy, seg, an
    );
endinterface

// File: rtl/disp_7seg_scan.sv
// Multi-digit 7-segment scan driver.
// A captured binary value is converted to BCD by a sequential double-dabble,
// with an optional two's-complement sign. The digits are then time-multiplexed
// onto one active-low segment bus.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros. Digit 0 always
// shows a numeral, and the sign stays on the top digit.
module disp_7seg_scan #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    disp_7seg_scan_if.slave  bus
);

    localparam int BCD_W  = DIGITS * 4;
    localparam int CNT_W  = $clog2(WIDTH);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = $clog2(DIGITS);

    localparam logic [6:0] DASH  = 7'h3F;
    localparam logic [6:0] BLANK = 7'h7F;

    // 10**n as a 64-bit constant; large enough for WIDTH up to 32 and DIGITS up to 8
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    // A magnitude at or above these limits cannot fit in the available digits
    localparam logic [63:0] LIMIT_POS = pow10(DIGITS);
    localparam logic [63:0] LIMIT_NEG = pow10(DIGITS - 1);

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h18;
            default: glyph = BLANK;
        endcase
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_SHIFT} state_t;

    state_t             state;
    logic               busy;
    logic [WIDTH-1:0]   val_q;
    logic               sgn_q;
    logic               neg_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   mag;
    logic [BCD_W-1:0]   bcd;
    logic [CNT_W-1:0]   cnt;

    logic               neg_c;
    logic [WIDTH-1:0]   mag_c;
    logic               ovf_c;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;
    logic               disp_wr;
    logic [6:0]         disp_in [DIGITS];
    logic [6:0]         disp    [DIGITS];

    logic [SCAN_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]   idx;
    logic [6:0]         seg;
    logic [DIGITS-1:0]  an;

    assign bus.busy = busy;
    assign bus.seg  = seg;
    assign bus.an   = an;

    // Sign and magnitude of the captured value; -8'h80 wraps to 8'h80, which reads as 128 unsigned
    always_comb begin
        neg_c = sgn_q & val_q[WIDTH-1];
        mag_c = neg_c ? -val_q : val_q;
        ovf_c = neg_c ? (64'(mag_c) >= LIMIT_NEG) : (64'(mag_c) >= LIMIT_POS);
    end

    // Double-dabble step: add 3 to every nibble >= 5, then shift in the next magnitude bit
    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < DIGITS; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj[BCD_W-2:0], mag[WIDTH-1]};
    end

    assign disp_wr = (state == S_SHIFT) && (cnt == CNT_W'(WIDTH - 1));

    // Glyphs for the display register, built from the BCD that the final shift produces
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic nz_above;
        nz_above = 1'b0;
`endif
        // NOTE: every element gets a default first, so no path through the loop can infer a latch.
        for (int i = 0; i < DIGITS; i++) disp_in[i] = BLANK;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ovf_q) begin
                disp_in[i] = DASH;
            end else if (neg_q && (i == DIGITS - 1)) begin
                disp_in[i] = DASH;
            end else begin
`ifdef LEADING_ZERO_BLANK_EN
                if (bcd_next[i*4 +: 4] != 4'd0) nz_above = 1'b1;
                disp_in[i] = (nz_above || (i == 0)) ? glyph(bcd_next[i*4 +: 4]) : BLANK;
`else
                disp_in[i] = glyph(bcd_next[i*4 +: 4]);
`endif
            end
        end
    end

    // Conversion FSM: capture, prepare sign/magnitude, then WIDTH double-dabble shifts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            val_q <= '0;
            sgn_q <= 1'b0;
            neg_q <= 1'b0;
            ovf_q <= 1'b0;
            mag   <= '0;
            bcd   <= '0;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every read below sees pre-edge values.
            unique case (state)
                S_IDLE: begin
                    if (bus.load) begin
                        val_q <= bus.in_val;
                        sgn_q <= bus.in_signed;
                        busy  <= 1'b1;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    neg_q <= neg_c;
                    mag   <= mag_c;
                    ovf_q <= ovf_c;
                    bcd   <= '0;
                    cnt   <= '0;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    bcd <= bcd_next;
                    mag <= {mag[WIDTH-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (disp_wr) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Display register: updated once per conversion, blanked by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small register array is reset on purpose, because the display must come up blank.
            for (int i = 0; i < DIGITS; i++) disp[i] <= BLANK;
        end else if (disp_wr) begin
            for (int i = 0; i < DIGITS; i++) disp[i] <= disp_in[i];
        end
    end

    // Scan: dwell SCAN_DIV cycles per digit; seg and an are registered together to avoid ghosting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= BLANK;
            an       <= '1;
        end else begin
            if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an  <= ~(DIGITS'(1) << idx);
            // Bypass the display register on its update edge so new digits appear as busy falls
            seg <= disp_wr ? disp_in[idx] : disp[idx];
        end
    end

endmodule
